// File: rtl/serial_comparator.sv
// Bit-serial signed/unsigned magnitude comparator, operands LSB first.
// Result flags are registered and held until the next completed compare.
module serial_comparator #(
   parameter int width       = 8,
   parameter bit signed_mode = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic equal,
   output logic greater,
   output logic lower
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   typedef enum logic [1:0] {
      REL_EQ = 2'd0,
      REL_GT = 2'd1,
      REL_LT = 2'd2
   } rel_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   rel_e            rel_q, rel_d;
   rel_e            fin;
   logic            done_q, done_d;
   logic            eq_q, eq_d;
   logic            gt_q, gt_d;
   logic            lt_q, lt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rel_q   <= REL_EQ;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      fin     = rel_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               rel_d   = REL_EQ;
            end
         end
         SHIFT: begin
            if (start) begin
               cnt_d = '0;
               rel_d = REL_EQ;
            end else if (bit_valid) begin
               if (cnt_q == LAST) begin
                  // In signed mode a set sign bit makes the operand smaller
                  if (a_bit != b_bit) begin
                     fin = (a_bit ^ signed_mode) ? REL_GT : REL_LT;
                  end
                  eq_d    = (fin == REL_EQ);
                  gt_d    = (fin == REL_GT);
                  lt_d    = (fin == REL_LT);
                  done_d  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
                  rel_d   = REL_EQ;
               end else begin
                  if (a_bit != b_bit) begin
                     rel_d = a_bit ? REL_GT : REL_LT;
                  end
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = (state_q == SHIFT);
   assign done    = done_q;
   assign equal   = eq_q;
   assign greater = gt_q;
   assign lower   = lt_q;

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
Bit-serial signed/unsigned magnitude comparator. Operands A and B arrive one bit per accepted beat, LSB first, on a two-wire serial interface. The block produces registered equal/greater/lower flags with a one-cycle done strobe. It is the receiving end for operands shifted out of a serializer; the result matches a parallel width-bit comparison of the same A and B.

Parameters:
width, 8, operand width in bits; legal range 2..32
signed_mode, 1, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a new comparison
bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
a_bit  input  1  current bit of operand A, LSB first
b_bit  input  1  current bit of operand B, LSB first
busy  output  1  high while a comparison is collecting bits
done  output  1  one-cycle pulse: result flags updated
equal  output  1  A == B (registered, held)
greater  output  1  A > B (registered, held)
lower  output  1  A < B (registered, held)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit counter=0, running relation=EQ; busy=0, done=0, equal=0, greater=0, lower=0. Reset mid-comparison discards all partial state.
- Exactly one of equal/greater/lower is 1 after the first done. All three are 0 only between reset and the first done.
- States:
  - IDLE: busy=0. start=1 -> SHIFT with counter=0 and relation=EQ. A bit_valid in the same cycle as start is ignored. bit_valid without start is ignored.
  - SHIFT: busy=1. On each edge with bit_valid=1, consume one bit and increment the counter. bit_valid=0 is a stall; it has no limit and changes no state.
- Relation update for non-MSB bits (counter < width-1):
  - a_bit=b_bit: relation is unchanged.
  - a_bit=1, b_bit=0: relation=GT.
  - a_bit=0, b_bit=1: relation=LT.
  - A higher-order differing bit overrides any lower-order result.
- MSB bit (counter == width-1):
  - a_bit=b_bit: the final result is the running relation.
  - Bits differ, signed_mode=1: a_bit=1 -> LT, else GT (sign bit dominates).
  - Bits differ, signed_mode=0: a_bit=1 -> GT, else LT.
  - On that edge, equal/greater/lower load the final result, done=1 for the following cycle only, and state returns to IDLE (busy=0 in the same cycle as done).
- Latency: done is high in the cycle immediately after the edge that consumes the MSB. Minimum comparison time is 1 (start) + width cycles.
- start during SHIFT: restart. Partial state is discarded, counter=0, relation=EQ, and state stays in SHIFT. Any bit_valid in that cycle is ignored. No done is issued for the aborted comparison, even if that cycle carried the MSB.
- start in the cycle done is high: legal. The new comparison begins and the flags keep the previous result until the next done.
- Flags are never combinationally derived from the inputs. They change only on the done-producing edge or on reset.
- Counter width is clog2(width). It never wraps, because the MSB edge always exits SHIFT.

Test Plan:
- width=8, signed_mode=1. start, then A=0x05, B=0x03 as 8 back-to-back beats -> done high exactly 9 cycles after start; greater=1, equal=0, lower=0; busy low in the done cycle.
- signed_mode=1, A=0xFF (-1), B=0x01 -> lower=1. Same stimulus with signed_mode=0 -> greater=1. A=0x80, B=0x7F, signed -> lower=1.
- A=B=0x80 and A=B=0x00 -> equal=1, each with a single done pulse. Flags stay held for 20 idle cycles with no spurious done.
- A=0x12, B=0x21 with bit_valid deasserted for 3 cycles between bits 2/3 and 5/6 -> lower=1; done arrives 6 cycles later than in the no-stall case.
- Restart: send 5 bits, assert start, then full A=0x40, B=0x40 -> only one done, equal=1. Start coincident with the MSB beat -> no done; the restarted compare completes normally.
- Assert rst_n=0 asynchronously mid-SHIFT (between clock edges) -> busy, done and all flags 0 immediately. After release, start + A=0x7F, B=0x80 signed -> greater=1.
